// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//
// Multi-cycle multiply/divide controller that sits beside the EX-stage ALU.
// One command per start pulse is accepted in IDLE. Multiply- and divide-class
// commands latch their operands, hold busy for a fixed number of cycles and
// then commit the result to the architectural HI/LO registers. mthi/mtlo write
// HI/LO at the same edge and never raise busy. Any start seen while busy is
// ignored; the hazard unit is expected to stall on busy|start.
//
// Parameters:
//   MULT_CYCLES  busy duration for mult/multu (and madd family), 1..15
//   DIV_CYCLES   busy duration for div/divu, 1..15
//
// Configuration macro:
//   MDU_MADD_EN  when defined, mdop 7..10 (madd, maddu, msub, msubu) are
//                multi-cycle accumulate ops with MULT_CYCLES latency;
//                otherwise they are treated as no-ops.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   asynchronous active-high reset
//   start  in   command valid, sampled only in IDLE
//   mdop   in   [3:0] command code
//   A      in   [31:0] rs operand (dividend / multiplicand / mthi-mtlo source)
//   B      in   [31:0] rt operand (divisor / multiplier)
//   busy   out  high while a multi-cycle op is in flight
//   hi     out  [31:0] architectural HI register
//   lo     out  [31:0] architectural LO register
// -----------------------------------------------------------------------------
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   state_e      state;
   logic [3:0]  cnt;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [3:0]  op_q;

   // ---------------------------------------------------------------------------
   // Command decode: which codes start a multi-cycle operation, and how long.
   // ---------------------------------------------------------------------------
   logic       long_op;
   logic [3:0] long_cnt;

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      long_op  = 1'b0;
      long_cnt = MULT_LOAD;
      case (mdop)
         OP_MULT, OP_MULTU: long_op = 1'b1;
         OP_DIV, OP_DIVU: begin
            long_op  = 1'b1;
            long_cnt = DIV_LOAD;
         end
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Result datapath, evaluated from the latched operands. Only sampled into
   // HI/LO on the completion edge, so intermediate values are never visible.
   // ---------------------------------------------------------------------------
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_s;
   logic [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;

   // Low 64 bits of a product of sign-extended operands equal the signed product.
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide via magnitudes: quotient truncates toward zero, remainder
   // takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000, rem 0.
   assign a_mag = a_q[31] ? -a_q : a_q;
   assign b_mag = b_q[31] ? -b_q : b_q;
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign q_s   = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
   assign r_s   = a_q[31] ? -r_mag : r_mag;
   assign q_u   = a_q / b_q;
   assign r_u   = a_q % b_q;

`ifdef MDU_MADD_EN
   logic [63:0] acc;
   assign acc = {hi, lo};
`endif

   logic        res_we;
   logic [63:0] res;

   always_comb begin
      res_we = 1'b0;
      res    = {hi, lo};
      case (op_q)
         OP_MULT: begin
            res_we = 1'b1;
            res    = prod_s;
         end
         OP_MULTU: begin
            res_we = 1'b1;
            res    = prod_u;
         end
         // Divide by zero leaves HI/LO untouched.
         OP_DIV: begin
            res_we = (b_q != 32'd0);
            res    = {r_s, q_s};
         end
         OP_DIVU: begin
            res_we = (b_q != 32'd0);
            res    = {r_u, q_u};
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            res_we = 1'b1;
            res    = acc + prod_s;
         end
         OP_MADDU: begin
            res_we = 1'b1;
            res    = acc + prod_u;
         end
         OP_MSUB: begin
            res_we = 1'b1;
            res    = acc - prod_s;
         end
         OP_MSUBU: begin
            res_we = 1'b1;
            res    = acc - prod_u;
         end
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered busy/hi/lo.
   // The counter is loaded with N at the start edge and the commit happens on
   // the edge where it steps from 1 to 0, giving exactly N busy cycles.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         cnt   <= 4'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         op_q  <= OP_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (long_op) begin
                     a_q   <= A;
                     b_q   <= B;
                     op_q  <= mdop;
                     cnt   <= long_cnt;
                     state <= BUSY;
                     busy  <= 1'b1;
                  end else if (mdop == OP_MTHI) begin
                     hi <= A;
                  end else if (mdop == OP_MTLO) begin
                     lo <= A;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (res_we) begin
                     hi <= res[63:32];
                     lo <= res[31:0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
//
// Scoreboard bench for mdu_ctrl. The stimulus thread issues commands, runs a
// 64-bit arithmetic reference model of HI/LO and queues the expected HI/LO and
// busy length. A monitor thread pops each expectation, counts busy cycles and
// compares HI/LO once busy is low. Honours MDU_MADD_EN the same way as the RTL.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdop;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   mdu_ctrl #(
      .MULT_CYCLES(MULT_N),
      .DIV_CYCLES (DIV_N)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .start(start),
      .mdop (mdop),
      .A    (A),
      .B    (B),
      .busy (busy),
      .hi   (hi),
      .lo   (lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: architectural HI/LO updated with plain 64-bit arithmetic.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      string       name;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      longint          sa, sb_v, sprod;
      longint unsigned ua, ub, uprod, acc;
      sa    = longint'(int'(a));
      sb_v  = longint'(int'(b));
      ua    = longint'(a) & 64'h0000_0000_FFFF_FFFF;
      ub    = longint'(b) & 64'h0000_0000_FFFF_FFFF;
      sprod = sa * sb_v;
      uprod = ua * ub;
      acc   = {m_hi, m_lo};
      lat   = 0;
      case (op)
         4'd1: begin lat = MULT_N; {m_hi, m_lo} = sprod; end
         4'd2: begin lat = MULT_N; {m_hi, m_lo} = uprod; end
         4'd3: begin
            lat = DIV_N;
            if (b != 0) begin
               m_lo = 32'(sa / sb_v);
               m_hi = 32'(sa % sb_v);
            end
         end
         4'd4: begin
            lat = DIV_N;
            if (b != 0) begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         4'd5: m_hi = a;
         4'd6: m_lo = a;
`ifdef MDU_MADD_EN
         4'd7:  begin lat = MULT_N; {m_hi, m_lo} = acc + 64'(sprod); end
         4'd8:  begin lat = MULT_N; {m_hi, m_lo} = acc + uprod; end
         4'd9:  begin lat = MULT_N; {m_hi, m_lo} = acc - 64'(sprod); end
         4'd10: begin lat = MULT_N; {m_hi, m_lo} = acc - uprod; end
`endif
         default: ;
      endcase
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: pops one expectation per command, counts busy-high cycles, then
   // compares latency and HI/LO in the first cycle busy is low.
   // ---------------------------------------------------------------------------
   bit   tracking = 1'b0;
   exp_t cur;
   int   bcnt;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            sb.delete();
            tracking = 1'b0;
         end else begin
            if (!tracking && sb.size() > 0) begin
               cur      = sb.pop_front();
               tracking = 1'b1;
               bcnt     = 0;
            end
            if (tracking) begin
               if (busy === 1'b1) begin
                  bcnt++;
                  if (bcnt > 20) begin
                     check({cur.name, "_busy_timeout"}, 64'(bcnt), 64'(cur.lat));
                     tracking = 1'b0;
                  end
               end else begin
                  check({cur.name, "_latency"}, 64'(bcnt), 64'(cur.lat));
                  check({cur.name, "_hi"}, 64'(hi), 64'(cur.hi));
                  check({cur.name, "_lo"}, 64'(lo), 64'(cur.lo));
                  tracking = 1'b0;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      exp_t e;
      int   lat;
      @(negedge clk);
      start = 1'b1;
      mdop  = op;
      A     = a;
      B     = b;
      @(posedge clk);
      model(op, a, b, lat);
      e.hi   = m_hi;
      e.lo   = m_lo;
      e.lat  = lat;
      e.name = name;
      sb.push_back(e);
      #1;
      start = 1'b0;
      mdop  = 4'($urandom_range(0, 15));
      A     = $urandom;
      B     = $urandom;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !tracking && busy === 1'b0) return;
      end
      checks++;
      errors++;
      $display("FAIL %s_wait_idle: actual busy/pending after 40 cycles, required idle", name);
   endtask

   task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
      issue(name, op, a, b);
      wait_idle(name);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [3:0]  op;
      logic [31:0] ra, rb;

      reset = 1'b1;
      start = 1'b0;
      mdop  = 4'd0;
      A     = 32'd0;
      B     = 32'd0;
      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed cases.
      run("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3);
      run("divu_100_7", 4'd4, 32'd100, 32'd7);
      run("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2);
      run("mthi", 4'd5, 32'h1234_5678, 32'h0);
      run("mtlo", 4'd6, 32'hCAFE_F00D, 32'h0);
      run("div_by_zero", 4'd3, 32'd55, 32'd0);
      run("divu_by_zero", 4'd4, 32'hFFFF_0000, 32'd0);
      run("div_overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run("div_neg_neg", 4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE);

      // multu with a start pulse (mtlo) and operand changes while busy.
      issue("multu_ignore", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      mdop  = 4'd6;
      A     = 32'hDEAD_BEEF;
      B     = 32'h0000_0001;
      @(negedge clk);
      start = 1'b0;
      A     = 32'h1111_1111;
      wait_idle("multu_ignore");

      // Accumulate family (no-ops when the feature is compiled out).
      run("madd_mthi0", 4'd5, 32'd0, 32'd0);
      run("madd_mtloF", 4'd6, 32'hFFFF_FFFF, 32'd0);
      run("maddu_1_1", 4'd8, 32'd1, 32'd1);
      run("madd_s", 4'd7, 32'hFFFF_FFFF, 32'd5);
      run("msub_s", 4'd9, 32'd7, 32'hFFFF_FFFD);
      run("msubu", 4'd10, 32'hFFFF_FFFF, 32'd2);

      // None and illegal codes.
      run("op_none", 4'd0, 32'hAAAA_AAAA, 32'd9);
      run("op_illegal", 4'd15, 32'h5555_5555, 32'd9);

      // Randomized commands with operand patterns that favour corner cases.
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = $urandom_range(0, 50); rb = $urandom_range(0, 9); end
            2: begin ra = $urandom; rb = 32'd0; end
            default: begin
               ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
               rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
            end
         endcase
         run("random", op, ra, rb);
      end

      // Asynchronous reset in the third cycle of a divide.
      run("pre_reset_mthi", 4'd5, 32'h0BAD_F00D, 32'd0);
      issue("div_aborted", 4'd4, 32'd1000, 32'd3);
      repeat (3) @(posedge clk);
      #2;
      check("busy_before_reset", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      check("async_reset_busy", 64'(busy), 64'd0);
      check("async_reset_hi", 64'(hi), 64'd0);
      check("async_reset_lo", 64'(lo), 64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      check("no_late_commit_busy", 64'(busy), 64'd0);
      check("no_late_commit_hi", 64'(hi), 64'd0);
      check("no_late_commit_lo", 64'(lo), 64'd0);

      // Recovery after reset.
      run("post_reset_mult", 4'd1, 32'd12345, 32'hFFFF_FF00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual simulation still running, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller for the pipelined CPU. Sits beside the single-cycle ALU in the EX stage.
- Accepts one multiply, divide or HI/LO-move command per start pulse and latches its operands.
- Holds busy for a fixed number of cycles, then commits the result to the architectural HI/LO registers.
- The hazard unit uses busy/start to stall the pipeline while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy duration for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  command valid for this cycle; sampled only in IDLE.
- mdop  input  4  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; others none.
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- B  input  32  operand rt (divisor / multiplier).
- busy  output  1  high while a multi-cycle op is in flight.
- hi  output  32  architectural HI register (mfhi source).
- lo  output  32  architectural LO register (mflo source).

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, hi=0, lo=0, counter=0, state=IDLE.
  - Any in-flight result is discarded.
- States: IDLE, BUSY.
- IDLE, start=1, mult-class op sampled at edge t:
  - Latch A, B and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - busy=1 from after edge t until edge t+N.
- BUSY:
  - Counter decrements each edge.
  - At edge t+N (counter reaches 0), HI/LO are written and state returns to IDLE; busy falls at that same edge.
  - New HI/LO values are visible in the first cycle busy=0.
- IDLE, start=1, mthi/mtlo:
  - hi (or lo) is written with A at that edge.
  - busy stays 0; no latency beyond one edge.
- IDLE, start=1, mdop none/illegal: no effect.
- start while BUSY: ignored entirely, including mthi/mtlo. Stalling is the pipeline's responsibility (hazard unit stalls on busy|start for md-class and mfhi/mflo instructions).
- Operands latched at start are used for the whole operation; A/B changes during BUSY have no effect.
- mult: {hi,lo} = signed(A)*signed(B), 64-bit product.
- multu: {hi,lo} = unsigned(A)*unsigned(B), 64-bit product.
- div:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: lo = A/B, hi = A%B, unsigned.
- Divide by zero: still takes DIV_CYCLES with busy asserted; hi/lo unchanged at completion.
- hi/lo outputs always reflect the committed registers; intermediate results are never exposed.
- Only one operation is in flight at a time; there is no queue.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - mdop 7..10 are legal multi-cycle ops with MULT_CYCLES latency.
  - madd/maddu: {hi,lo} += A*B, signed/unsigned product; 64-bit wrap-around.
  - msub/msubu: {hi,lo} -= A*B; 64-bit wrap-around.
  - The {hi,lo} accumulate base is the value at completion time, identical to the value at start since no writes occur while BUSY.
- Undefined: mdop 7..10 are treated as none; no busy, no state change.

Test Plan:
- Reset, then start mult A=0xFFFFFFFE B=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFA as busy falls.
- Start divu A=100 B=7 -> busy 10 cycles; then lo=14 hi=2. Start div A=-7 B=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- Start mthi A=0x12345678 in IDLE -> hi=0x12345678 after one edge, busy never rises. Start div with B=0 -> busy 10 cycles, hi/lo unchanged.
- During busy from multu A=B=0xFFFFFFFF, pulse start with mtlo and change A/B -> ignored; final hi=0xFFFFFFFE lo=0x00000001.
- Assert reset at cycle 3 of a div -> busy=0, hi=lo=0 immediately (asynchronous); no later commit occurs.
- With MDU_MADD_EN: hi=0 lo=0xFFFFFFFF, maddu A=1 B=1 -> hi=1 lo=0 after 5 cycles. Without the macro, the same command changes nothing and busy stays 0.
